// File: rtl/uart_tx_frame_gen.sv
// Parametrised UART transmitter: start bit, DATA_WIDTH data bits LSB-first,
// optional even/odd parity, one or two stop bits, runtime bit-time prescaler.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic                      parity_en,
    input  logic                      parity_type,
    input  logic                      stop2,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      data_out,
    output logic                      busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] tick_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic                      stop_cnt;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      parity_bit;
    logic                      parity_en_q;
    logic                      stop2_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;

    assign data_ready = ~busy;

    // data_out is loaded with the next bit's value on the same edge the state
    // advances, so the line changes exactly at bit boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            stop_cnt    <= 1'b0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            parity_en_q <= 1'b0;
            stop2_q     <= 1'b0;
            prescale_q  <= '0;
            data_out    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_out <= 1'b1;
                    busy     <= 1'b0;
                    tick_cnt <= '0;
                    if (data_valid) begin
                        shift_reg   <= data;
                        parity_bit  <= (^data) ^ parity_type;
                        parity_en_q <= parity_en;
                        stop2_q     <= stop2;
                        prescale_q  <= prescale;
                        state       <= START;
                        data_out    <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    if (tick_cnt != prescale_q) begin
                        tick_cnt <= tick_cnt + PRESCALE_WIDTH'(1);
                    end else begin
                        tick_cnt <= '0;
                        case (state)
                            START: begin
                                state    <= DATA;
                                bit_idx  <= '0;
                                data_out <= shift_reg[0];
                            end
                            DATA: begin
                                if (bit_idx == LAST_IDX) begin
                                    stop_cnt <= 1'b0;
                                    if (parity_en_q) begin
                                        state    <= PARITY;
                                        data_out <= parity_bit;
                                    end else begin
                                        state    <= STOP;
                                        data_out <= 1'b1;
                                    end
                                end else begin
                                    bit_idx   <= bit_idx + IDX_W'(1);
                                    shift_reg <= shift_reg >> 1;
                                    data_out  <= shift_reg[1];
                                end
                            end
                            PARITY: begin
                                state    <= STOP;
                                stop_cnt <= 1'b0;
                                data_out <= 1'b1;
                            end
                            STOP: begin
                                if (stop2_q && !stop_cnt) begin
                                    stop_cnt <= 1'b1;
                                end else begin
                                    state    <= IDLE;
                                    busy     <= 1'b0;
                                    data_out <= 1'b1;
                                end
                            end
                            default: begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                data_out <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: per-cycle comparison of two instances (W=8 and
// W=5 with a 4-bit prescaler) against a queue-based frame model.
module tb_uart_tx_frame_gen;

    typedef bit bit_q_t[$];

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        dv;
    logic        pe;
    logic        pt;
    logic        s2;
    logic [15:0] pre;
    logic        rdy8, dout8, busy8;
    logic        rdy5, dout5, busy5;

    int checks   = 0;
    int failures = 0;

    bit_q_t q8;
    bit_q_t q5;
    bit     r8, r5;

    logic tr_out  [0:199];
    logic tr_busy [0:199];
    logic tr_rdy  [0:199];

    uart_tx_frame_gen #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst), .data(din), .data_valid(dv), .data_ready(rdy8),
        .parity_en(pe), .parity_type(pt), .stop2(s2), .prescale(pre),
        .data_out(dout8), .busy(busy8)
    );

    uart_tx_frame_gen #(.DATA_WIDTH(5), .PRESCALE_WIDTH(4)) dut5 (
        .clk(clk), .rst(rst), .data(din[4:0]), .data_valid(dv), .data_ready(rdy5),
        .parity_en(pe), .parity_type(pt), .stop2(s2), .prescale(pre[3:0]),
        .data_out(dout5), .busy(busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Whole frame as a per-clock line sequence, built from the frame rules.
    function automatic bit_q_t expand(int w, logic [7:0] d, bit pe_i, bit pt_i,
                                      bit s2_i, int pre_i);
        bit     bits[$];
        bit_q_t r;
        int     ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe_i) bits.push_back(bit'(ones % 2) ^ pt_i);
        bits.push_back(1'b1);
        if (s2_i) bits.push_back(1'b1);
        foreach (bits[k])
            for (int j = 0; j <= pre_i; j++) r.push_back(bits[k]);
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q8.delete();
            q5.delete();
        end else begin
            r8 = (q8.size() == 0);
            r5 = (q5.size() == 0);
            if (!r8) void'(q8.pop_front());
            if (!r5) void'(q5.pop_front());
            if (r8 && dv) q8 = expand(8, din, pe, pt, s2, int'(pre));
            if (r5 && dv) q5 = expand(5, {3'b000, din[4:0]}, pe, pt, s2, int'(pre[3:0]));
        end
    end

    always @(negedge clk) begin
        chk("out8",  32'(dout8), (q8.size() > 0) ? 32'(q8[0]) : 32'd1);
        chk("busy8", 32'(busy8), 32'(q8.size() > 0));
        chk("rdy8",  32'(rdy8),  32'(q8.size() == 0));
        chk("out5",  32'(dout5), (q5.size() > 0) ? 32'(q5[0]) : 32'd1);
        chk("busy5", 32'(busy5), 32'(q5.size() > 0));
        chk("rdy5",  32'(rdy5),  32'(q5.size() == 0));
    end

    task automatic wait_ready();
        int n = 0;
        while (!(rdy8 && rdy5) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input bit pe_i, input bit pt_i,
                        input bit s2_i, input logic [15:0] pre_i);
        wait_ready();
        din = d; pe = pe_i; pt = pt_i; s2 = s2_i; pre = pre_i;
        dv  = 1'b1;
        @(negedge clk);
        dv  = 1'b0;
    endtask

    task automatic record(input bit use5, input int n);
        for (int i = 0; i < n; i++) begin
            tr_out[i]  = use5 ? dout5 : dout8;
            tr_busy[i] = use5 ? busy5 : busy8;
            tr_rdy[i]  = use5 ? rdy5  : rdy8;
            @(negedge clk);
        end
    endtask

    function automatic int count_ones(int lo, int hi, bit use_busy);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += use_busy ? int'(tr_busy[i]) : int'(tr_out[i]);
        return c;
    endfunction

    initial begin
        int exp_b[12]   = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};
        int exp_r[11]   = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        int exp_w5[9]   = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
        logic [7:0] pd[4] = '{8'hA5, 8'hA5, 8'h07, 8'h07};
        bit         pp[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int         pexp[4] = '{0, 1, 1, 0};
        logic [7:0] hs;

        rst = 1'b0; dv = 1'b0; din = '0; pe = 1'b0; pt = 1'b0; s2 = 1'b0; pre = '0;
        repeat (3) @(negedge clk);
        chk("reset_out",  32'(dout8), 32'd1);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_rdy",  32'(rdy8),  32'd1);
        rst = 1'b1;
        @(negedge clk);

        send(8'hA5, 1'b0, 1'b0, 1'b0, 16'd0);
        record(1'b0, 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("basic_out%0d", i), 32'(tr_out[i]), 32'(exp_b[i]));
            chk($sformatf("basic_busy%0d", i), 32'(tr_busy[i]), 32'(i < 10));
        end
        chk("basic_rdy10", 32'(tr_rdy[10]), 32'd1);

        for (int k = 0; k < 4; k++) begin
            send(pd[k], 1'b1, pp[k], 1'b0, 16'd0);
            record(1'b0, 12);
            chk($sformatf("parity%0d_bit", k), 32'(tr_out[9]), 32'(pexp[k]));
            chk($sformatf("parity%0d_len", k), 32'(count_ones(0, 11, 1'b1)), 32'd11);
        end

        for (int k = 0; k < 2; k++) begin
            send(8'h00, 1'b1, bit'(k), 1'b1, 16'd3);
            record(1'b0, 52);
            chk($sformatf("pre3_busy_len%0d", k), 32'(count_ones(0, 51, 1'b1)), 32'd48);
            chk($sformatf("pre3_parity%0d", k), 32'(count_ones(36, 39, 1'b0)), 32'(4 * k));
            chk($sformatf("pre3_stop_high%0d", k), 32'(count_ones(40, 47, 1'b0)), 32'd8);
            chk($sformatf("pre3_last_data%0d", k), 32'(count_ones(32, 35, 1'b0)), 32'd0);
        end

        wait_ready();
        din = 8'h3C; pe = 1'b1; pt = 1'b0; s2 = 1'b0; pre = 16'd0; dv = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            tr_out[i]  = dout8;
            tr_busy[i] = busy8;
            if (i == 4) begin
                din = 8'hFF;
                pt  = 1'b1;
            end
            @(negedge clk);
        end
        dv = 1'b0;
        hs = 8'h3C;
        for (int i = 0; i < 8; i++)
            chk($sformatf("hs_data%0d", i), 32'(tr_out[i + 1]), 32'(hs[i]));
        chk("hs_parity1", 32'(tr_out[9]),  32'd0);
        chk("hs_busy_len", 32'(count_ones(0, 10, 1'b1)), 32'd11);
        chk("hs_idle_gap", 32'(tr_busy[11]), 32'd0);
        chk("hs_second_accept", 32'(tr_busy[12]), 32'd1);
        chk("hs_second_start", 32'(tr_out[12]), 32'd0);
        chk("hs_parity2", 32'(tr_out[21]), 32'd1);
        chk("hs_third_accept", 32'(tr_busy[24]), 32'd1);

        send(8'h55, 1'b0, 1'b0, 1'b0, 16'd3);
        repeat (17) @(negedge clk);
        #2;
        chk("rst_pre_bit3", 32'(dout8), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_async_out",  32'(dout8), 32'd1);
        chk("rst_async_busy", 32'(busy8), 32'd0);
        chk("rst_async_rdy",  32'(rdy8),  32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(8'h81, 1'b0, 1'b0, 1'b0, 16'd0);
        record(1'b0, 11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("post_rst_out%0d", i), 32'(tr_out[i]), 32'(exp_r[i]));

        send(8'h1F, 1'b1, 1'b0, 1'b0, 16'd0);
        record(1'b1, 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("w5_out%0d", i), 32'(tr_out[i]), 32'(exp_w5[i]));
            chk($sformatf("w5_busy%0d", i), 32'(tr_busy[i]), 32'(i < 8));
        end

        send(8'h1F, 1'b1, 1'b0, 1'b0, 16'h000F);
        record(1'b1, 140);
        chk("w5_maxpre_len", 32'(count_ones(0, 139, 1'b1)), 32'd128);
        chk("w5_maxpre_parity", 32'(count_ones(96, 111, 1'b0)), 32'd16);
        chk("w5_maxpre_start", 32'(count_ones(0, 15, 1'b0)), 32'd0);

        wait_ready();
        repeat (1500) begin
            din = 8'($urandom);
            dv  = ($urandom_range(0, 3) == 0);
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            s2  = 1'($urandom);
            pre = 16'($urandom_range(0, 2));
            @(negedge clk);
        end
        dv = 1'b0;
        wait_ready();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
